mbldcm_drive_core: RTL
======================

# mbldcm_drive_core

Second-generation BLDC motor drive core: a parametrised, bidirectional six-step commutation engine.
- A programmable-rate phase sequencer selects the active high/low switch pair.
- The high-side is PWM-chopped.
- Dead-time on-delay is inserted per switch, and a shoot-through interlock is applied per leg before the polarity-configurable U/V/W gate outputs.
- The block sits between the register/bus front end, which drives the control inputs, and the six gate-driver pins.

## Interface
Parameters:
- pStagesPerStep, 2: phase stages per commutation step; total stages N = 6*pStagesPerStep (legal 1..8).
- pPhaseWidth, 6: width of phase counter/ports; must satisfy 2^pPhaseWidth >= N.
- pPwmWidth, 8: PWM counter and duty width.
- pDeadTime, 4: on-delay in clocks applied to every switch turn-on (0..255).
- pInvertUh, pInvertUl, pInvertVh, pInvertVl, pInvertWh, pInvertWl, 1'b0: per-output polarity inversion.

Ports:
- iClock  in  1  sole clock; all state on rising edge.
- iReset_n  in  1  asynchronous active-low reset.
- iEnable  in  1  drive enable; low forces all switches inactive.
- iDiv  in  32  clocks per phase stage; 0 = no advance.
- iStop  in  1  freeze phase and divider counter.
- iDir  in  1  0 = phase increments, 1 = phase decrements.
- iDuty  in  pPwmWidth  high-side duty; all-ones = 100%.
- iPhaseUpdate  in  pPhaseWidth  phase value to load.
- iLatchPhaseUpdate  in  1  load iPhaseUpdate this cycle.
- oPhase  out  pPhaseWidth  current phase stage 0..N-1.
- oStepStrobe  out  1  one-cycle pulse on every phase advance.
- oUh, oUl, oVh, oVl, oWh, oWl  out  1  gate outputs (after inversion).

## Operation
- Divider: 32-bit counter cnt.
  - Advance condition: iDiv != 0, !iStop, no latch, and cnt == iDiv-1. On advance, cnt <= 0 and the phase advances; otherwise cnt increments while iDiv != 0 and !iStop.
  - iStop or iDiv == 0 holds cnt and phase.
  - An iDiv change takes effect immediately. If cnt >= iDiv, cnt <= 0 with no advance.
- Phase advance:
  - iDir = 0: phase+1, wrapping N-1 -> 0.
  - iDir = 1: phase-1, wrapping 0 -> N-1.
  - oStepStrobe = 1 in the cycle after each advance edge (registered).
- Latch: iLatchPhaseUpdate has priority over advance and iStop. It loads phase <= iPhaseUpdate (values >= N load 0) and sets cnt <= 0. Latch does not assert oStepStrobe.
- Commutation: step = phase / pStagesPerStep. Requested switch pairs:
  - 0 Uh+Vl
  - 1 Uh+Wl
  - 2 Vh+Wl
  - 3 Vh+Ul
  - 4 Wh+Ul
  - 5 Wh+Vl
- PWM: free-running pPwmWidth counter pwm, wrapping all-ones -> 0, running regardless of iEnable.
  - A requested high-side is gated to pwm < iDuty, or always on when iDuty is all-ones.
  - Low-sides are not chopped.
- Enable: iEnable = 0 zeroes all requests.
- Dead-time: each switch has an on-delay counter.
  - The output asserts after its gated request has been continuously high for pDeadTime clocks.
  - A request drop deasserts the output on the next edge and clears the counter.
- Interlock: if both switches of a leg would be active, both are driven inactive. This state is unreachable in normal operation and is checked by assertion.
- Inversion: oX = active XOR pInvertX.

## Timing
- Reset values (async):
  - phase = 0, cnt = 0, pwm = 0, all on-delay counters = 0, oStepStrobe = 0.
  - Every gate output = its pInvert value (inactive level).
  - Outputs take their reset values immediately on iReset_n low, even mid-PWM or mid-dead-time.
- Phase period: N*iDiv clocks per electrical revolution; iDiv = 1 advances every clock.
- Stage timing: oPhase updates on the edge where cnt == iDiv-1.
- Gate response to a phase change or request change:
  - Falling (turn-off): 1 clock.
  - Rising (turn-on): pDeadTime+1 clocks; with pDeadTime = 0, 1 clock.
- Interlock timing: the turn-off of one switch in a leg and the turn-on of its complement are separated by at least pDeadTime clocks.
- PWM timing: high-side duty period is 2^pPwmWidth clocks. PWM-off intervals shorter than pDeadTime suppress re-turn-on until the counter completes.
- Enable timing:
  - iEnable falling: outputs inactive 1 clock later.
  - iEnable rising: outputs return after pDeadTime+1 clocks.
- Latch and iStop in the same cycle: the latch wins and the phase then holds. Latch and advance in the same cycle: the latch wins.

## Test plan
- Reset: hold iReset_n = 0 with pInvertUl = 1 -> oUl = 1, all other gate outputs 0, oPhase = 0, oStepStrobe = 0.
- Forward rotation: iEnable = 1, iDiv = 3, iDir = 0, iDuty = 8'hFF, pDeadTime = 0.
  - Required: oPhase steps 0,1,...,11,0 every 3 clocks, with one oStepStrobe per step.
  - Required: Uh+Vl active for phases 0-1, Uh+Wl for phases 2-3.
- Reverse and wrap: iDir = 1 from phase 0 -> next phase 11. Latch iPhaseUpdate = 13 -> phase 0 with cnt cleared; latch 5 during iStop = 1 -> phase 5 and held.
- Dead-time: pDeadTime = 4, transition from step 0 to step 1.
  - Required: Vl falls 1 clock after the phase edge; Wl rises 5 clocks after it; Uh is unaffected.
- PWM: iDuty = 64, pPwmWidth = 8, pDeadTime = 0, step 0.
  - Required: Uh high 64 of every 256 clocks; Vl high continuously.
  - Required: iEnable dropped mid-PWM -> all outputs inactive next clock.
- Edge cases: iDiv = 0 -> phase never advances.
  - Required: asynchronous reset asserted mid-dead-time -> outputs return to inversion levels immediately.
  - Required: on re-enable, all outputs stay inactive for pDeadTime clocks.

Source files
------------

// File: rtl/mbldcm_drive_core_if.sv
// Control/status bundle between the register front end and the BLDC drive core.
interface mbldcm_drive_core_if #(
  parameter int unsigned pPhaseWidth = 6,
  parameter int unsigned pPwmWidth   = 8
);
  logic                   iEnable;
  logic [31:0]            iDiv;
  logic                   iStop;
  logic                   iDir;
  logic [pPwmWidth-1:0]   iDuty;
  logic [pPhaseWidth-1:0] iPhaseUpdate;
  logic                   iLatchPhaseUpdate;
  logic [pPhaseWidth-1:0] oPhase;
  logic                   oStepStrobe;
  logic                   oUh;
  logic                   oUl;
  logic                   oVh;
  logic                   oVl;
  logic                   oWh;
  logic                   oWl;

  // Front end drives controls and observes status.
  modport master (
    output iEnable, iDiv, iStop, iDir, iDuty, iPhaseUpdate, iLatchPhaseUpdate,
    input  oPhase, oStepStrobe, oUh, oUl, oVh, oVl, oWh, oWl
  );

  // Drive core consumes controls and produces status and gate pins.
  modport slave (
    input  iEnable, iDiv, iStop, iDir, iDuty, iPhaseUpdate, iLatchPhaseUpdate,
    output oPhase, oStepStrobe, oUh, oUl, oVh, oVl, oWh, oWl
  );
endinterface

// File: rtl/mbldcm_drive_core.sv
// Six-step BLDC commutation core: phase sequencer, high-side PWM chopping,
// per-switch turn-on delay, per-leg interlock and output polarity.
module mbldcm_drive_core #(
  parameter int unsigned pStagesPerStep = 2,
  parameter int unsigned pPhaseWidth    = 6,
  parameter int unsigned pPwmWidth      = 8,
  parameter int unsigned pDeadTime      = 4,
  parameter logic        pInvertUh      = 1'b0,
  parameter logic        pInvertUl      = 1'b0,
  parameter logic        pInvertVh      = 1'b0,
  parameter logic        pInvertVl      = 1'b0,
  parameter logic        pInvertWh      = 1'b0,
  parameter logic        pInvertWl      = 1'b0
) (
  input logic                  iClock,
  input logic                  iReset_n,
  mbldcm_drive_core_if.slave   bus
);

  localparam int unsigned            NumStages = 6 * pStagesPerStep;
  localparam logic [pPhaseWidth-1:0] LastPhase = pPhaseWidth'(NumStages - 1);
  localparam logic [7:0]             DeadTime  = 8'(pDeadTime);

  // Switch indices into the per-switch vectors.
  localparam int unsigned Uh = 0;
  localparam int unsigned Ul = 1;
  localparam int unsigned Vh = 2;
  localparam int unsigned Vl = 3;
  localparam int unsigned Wh = 4;
  localparam int unsigned Wl = 5;

  logic [31:0]            r_cnt;
  logic [31:0]            w_cnt_d;
  logic [pPhaseWidth-1:0] r_phase;
  logic [pPhaseWidth-1:0] w_phase_d;
  logic [pPhaseWidth-1:0] w_phase_next;
  logic                   w_advance;
  logic                   r_strobe;
  logic [pPwmWidth-1:0]   r_pwm;
  logic                   w_pwm_on;
  logic [2:0]             w_step;
  logic [5:0]             w_req_raw;
  logic [5:0]             w_req;
  logic [7:0]             r_dt_cnt [6];
  logic [5:0]             r_act;
  logic [2:0]             w_leg_clash;
  logic [5:0]             w_on;

  // Neighbouring stage in the selected rotation direction, with wrap.
  always_comb begin
    if (bus.iDir) begin
      w_phase_next = (r_phase == '0) ? LastPhase : r_phase - pPhaseWidth'(1);
    end else begin
      w_phase_next = (r_phase == LastPhase) ? '0 : r_phase + pPhaseWidth'(1);
    end
  end

  // Divider and phase next-state; latch outranks stop and advance.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_phase_d = r_phase;
    w_advance = 1'b0;
    if (bus.iLatchPhaseUpdate) begin
      w_cnt_d   = '0;
      w_phase_d = (bus.iPhaseUpdate > LastPhase) ? '0 : bus.iPhaseUpdate;
    end else if ((bus.iDiv != '0) && !bus.iStop) begin
      if (r_cnt >= bus.iDiv) begin
        // Divider shrunk below the running count: restart without stepping.
        w_cnt_d = '0;
      end else if (r_cnt == bus.iDiv - 32'd1) begin
        w_cnt_d   = '0;
        w_advance = 1'b1;
        w_phase_d = w_phase_next;
      end else begin
        w_cnt_d = r_cnt + 32'd1;
      end
    end
  end

  // Divider, phase, step strobe and PWM counter state.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_cnt    <= '0;
      r_phase  <= '0;
      r_strobe <= 1'b0;
      r_pwm    <= '0;
    end else begin
      r_cnt    <= w_cnt_d;
      r_phase  <= w_phase_d;
      r_strobe <= w_advance;
      r_pwm    <= r_pwm + pPwmWidth'(1);
    end
  end

  assign w_step   = 3'(r_phase / pPhaseWidth'(pStagesPerStep));
  assign w_pwm_on = (bus.iDuty == '1) || (r_pwm < bus.iDuty);

  // Commutation table: requested high/low pair for the current step.
  always_comb begin
    w_req_raw = '0;
    case (w_step)
      3'd0: begin w_req_raw[Uh] = 1'b1; w_req_raw[Vl] = 1'b1; end
      3'd1: begin w_req_raw[Uh] = 1'b1; w_req_raw[Wl] = 1'b1; end
      3'd2: begin w_req_raw[Vh] = 1'b1; w_req_raw[Wl] = 1'b1; end
      3'd3: begin w_req_raw[Vh] = 1'b1; w_req_raw[Ul] = 1'b1; end
      3'd4: begin w_req_raw[Wh] = 1'b1; w_req_raw[Ul] = 1'b1; end
      3'd5: begin w_req_raw[Wh] = 1'b1; w_req_raw[Vl] = 1'b1; end
      default: w_req_raw = '0;
    endcase
  end

  // Enable gating on every switch, PWM chopping on high-sides only.
  always_comb begin
    w_req     = w_req_raw & {6{bus.iEnable}};
    w_req[Uh] = w_req[Uh] & w_pwm_on;
    w_req[Vh] = w_req[Vh] & w_pwm_on;
    w_req[Wh] = w_req[Wh] & w_pwm_on;
  end

  // Per-switch on-delay: assert only after the request has held for DeadTime clocks.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_act <= '0;
      for (int i = 0; i < 6; i++) begin
        r_dt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (!w_req[i]) begin
          r_dt_cnt[i] <= '0;
          r_act[i]    <= 1'b0;
        end else if (r_dt_cnt[i] == DeadTime) begin
          r_act[i] <= 1'b1;
        end else begin
          r_dt_cnt[i] <= r_dt_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Leg interlock: a leg with both switches active is forced fully off.
  always_comb begin
    w_leg_clash[0] = r_act[Uh] & r_act[Ul];
    w_leg_clash[1] = r_act[Vh] & r_act[Vl];
    w_leg_clash[2] = r_act[Wh] & r_act[Wl];
    w_on[Uh] = r_act[Uh] & ~w_leg_clash[0];
    w_on[Ul] = r_act[Ul] & ~w_leg_clash[0];
    w_on[Vh] = r_act[Vh] & ~w_leg_clash[1];
    w_on[Vl] = r_act[Vl] & ~w_leg_clash[1];
    w_on[Wh] = r_act[Wh] & ~w_leg_clash[2];
    w_on[Wl] = r_act[Wl] & ~w_leg_clash[2];
  end

  // The six-step table and turn-off-before-turn-on make a clash unreachable.
  a_no_shoot_through : assert property (@(posedge iClock) disable iff (!iReset_n)
    w_leg_clash == 3'b000);

  assign bus.oPhase      = r_phase;
  assign bus.oStepStrobe = r_strobe;
  assign bus.oUh         = w_on[Uh] ^ pInvertUh;
  assign bus.oUl         = w_on[Ul] ^ pInvertUl;
  assign bus.oVh         = w_on[Vh] ^ pInvertVh;
  assign bus.oVl         = w_on[Vl] ^ pInvertVl;
  assign bus.oWh         = w_on[Wh] ^ pInvertWh;
  assign bus.oWl         = w_on[Wl] ^ pInvertWl;

endmodule
